// File: rtl/rv32i_fetch_unit_if.sv
// rv32i_fetch_unit_if: fetch-side bus bundle.
// Carries imem, decode and redirect signals.
interface rv32i_fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             i_stall;
  logic             i_redirect;
  logic [WIDTH-1:0] i_redirect_pc;
  logic [WIDTH-1:0] o_imem_addr;
  logic [WIDTH-1:0] i_imem_inst;
  logic [WIDTH-1:0] o_id_pc;
  logic [WIDTH-1:0] o_id_inst;
  logic             o_id_valid;
  logic             o_fetch_fault;

  modport master (
    input  i_stall,
    input  i_redirect,
    input  i_redirect_pc,
    input  i_imem_inst,
    output o_imem_addr,
    output o_id_pc,
    output o_id_inst,
    output o_id_valid,
    output o_fetch_fault
  );

  modport slave (
    output i_stall,
    output i_redirect,
    output i_redirect_pc,
    output i_imem_inst,
    input  o_imem_addr,
    input  o_id_pc,
    input  o_id_inst,
    input  o_id_valid,
    input  o_fetch_fault
  );
endinterface

// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit: PC, synchronous imem request, decode hand-off.
// FETCH_MISALIGN_TRAP_EN enables the misaligned-redirect fault.
module rv32i_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP_INST = WIDTH'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst,
  rv32i_fetch_unit_if.master bus
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic             req_valid_q, req_valid_d;
  logic [WIDTH-1:0] hold_inst_q, hold_inst_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] target;
  logic             misalign;
  logic             fault_s;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;

  assign target   = bus.i_redirect_pc;
  assign misalign = |bus.i_redirect_pc[1:0];
  assign fault_s  = fault_q;

  // Sticky fault: set by a misaligned redirect, cleared by an aligned one.
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end

  // Fault update follows the redirect pulse only.
  always_comb begin
    fault_d = fault_q;
    if (bus.i_redirect) fault_d = misalign;
  end
`else
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  assign target   = bus.i_redirect_pc & ALIGN_MASK;
  assign misalign = 1'b0;
  assign fault_s  = misalign;
`endif

  // Pipeline state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      req_valid_q  <= 1'b0;
      hold_inst_q  <= NOP_INST;
      hold_valid_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      req_valid_q  <= req_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  // Next state: redirect beats stall, stall beats fault, else advance.
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    req_valid_d  = req_valid_q;
    hold_inst_d  = hold_inst_q;
    hold_valid_d = hold_valid_q;
    if (bus.i_redirect) begin
      pc_d         = target;
      req_valid_d  = 1'b0;
      hold_valid_d = 1'b0;
    end else if (bus.i_stall) begin
      if (!hold_valid_q) begin
        hold_inst_d  = bus.i_imem_inst;
        hold_valid_d = 1'b1;
      end
    end else begin
      req_pc_d     = pc_q;
      req_valid_d  = ~fault_s;
      hold_valid_d = 1'b0;
      if (!fault_s) pc_d = pc_q + WIDTH'(4);
    end
  end

  // Decode-side outputs; the held copy covers the stalled window.
  always_comb begin
    bus.o_imem_addr   = pc_q;
    bus.o_id_pc       = req_pc_q;
    bus.o_id_valid    = req_valid_q;
    bus.o_fetch_fault = fault_s;
    bus.o_id_inst     = bus.i_imem_inst;
    if (!req_valid_q)      bus.o_id_inst = NOP_INST;
    else if (hold_valid_q) bus.o_id_inst = hold_inst_q;
  end

endmodule

// File: doc/rv32i_fetch_unit.md
RV32I_FETCH_UNIT -- requirements
Module: rv32i_fetch_unit

Interface
- REQ-001: Parameter WIDTH, default 32, SHALL set the address/instruction width.
- REQ-002: Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded on reset.
- REQ-003: Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), SHALL set the instruction driven when output is invalid.
- REQ-004: clk  in  1  SHALL be the single clock; all state updates on its rising edge.
- REQ-005: rst  in  1  SHALL be the synchronous, active-high reset.
- REQ-006: i_stall  in  1  SHALL be the decode-stage back-pressure; 1 = hold current output.
- REQ-007: i_redirect  in  1  SHALL be the branch/jump taken pulse from execute.
- REQ-008: i_redirect_pc  in  WIDTH  SHALL be the redirect target, sampled when i_redirect=1.
- REQ-009: o_imem_addr  out  WIDTH  SHALL be the byte address to instruction memory, equal to the PC register.
- REQ-010: i_imem_inst  in  WIDTH  SHALL be instruction memory read data, valid one cycle after the address (synchronous read).
- REQ-011: o_id_pc  out  WIDTH  SHALL be the PC of the instruction handed to decode.
- REQ-012: o_id_inst  out  WIDTH  SHALL be the instruction handed to decode.
- REQ-013: o_id_valid  out  1  SHALL flag o_id_pc/o_id_inst as a real instruction.
- REQ-014: o_fetch_fault  out  1  SHALL flag a misaligned redirect (see Configuration).

Function
- REQ-015: State SHALL be: pc, req_pc_q, req_valid_q, hold_inst, hold_valid, fault_q.
- REQ-016: Next-PC priority SHALL be: rst > i_redirect > i_stall (hold) > fault_q (hold) > pc+4.
- REQ-017: pc+4 SHALL wrap modulo 2^WIDTH (32'hFFFF_FFFC -> 32'h0000_0000).
- REQ-018: When not stalled, req_pc_q <= pc and req_valid_q <= ~fault_q; o_id_pc = req_pc_q, o_id_valid = req_valid_q.
- REQ-019: Fetch-to-decode latency SHALL be 1 cycle: address issued in cycle N appears on o_id_* in cycle N+1.
- REQ-020: On first stall cycle (i_stall=1, hold_valid=0), hold_inst <= i_imem_inst and hold_valid <= 1; pc, req_pc_q, req_valid_q SHALL hold.
- REQ-021: o_id_inst SHALL be NOP_INST if o_id_valid=0, else hold_inst if hold_valid=1, else i_imem_inst.
- REQ-022: On the cycle i_stall deasserts, decode consumes the held instruction; hold_valid <= 0 at that edge and fetch resumes at the held pc with no gap or duplicate.
- REQ-023: On i_redirect=1 (regardless of i_stall): pc <= target, req_valid_q <= 0, hold_valid <= 0; the in-flight instruction is squashed; first target instruction is valid 2 cycles after redirect.
- REQ-024: o_id_valid SHALL never be 1 for the instruction in flight when i_redirect was asserted.

Reset
- REQ-025: On rst=1: pc <= RESET_PC, req_pc_q <= 0, req_valid_q <= 0, hold_inst <= NOP_INST, hold_valid <= 0, fault_q <= 0.
- REQ-026: During and in the cycle after reset: o_imem_addr = RESET_PC (after edge), o_id_valid = 0, o_id_inst = NOP_INST, o_id_pc = 0, o_fetch_fault = 0.
- REQ-027: Reset asserted mid-stall or mid-redirect SHALL override both and discard held state.

Configuration
- REQ-028: Macro FETCH_MISALIGN_TRAP_EN defined: a redirect with i_redirect_pc[1:0] != 0 SHALL set fault_q (drives o_fetch_fault), load pc with the target unchanged, and suppress all further valid output until the next aligned redirect or reset clears fault_q.
- REQ-029: Macro undefined: i_redirect_pc[1:0] SHALL be forced to 2'b00, fault logic absent, o_fetch_fault tied 0.

Verification
- REQ-030: Reset release, no stall, sequential mem -> o_id_pc 0,4,8,12 on consecutive cycles from 2nd cycle after reset, o_id_valid=1.
- REQ-031: i_stall=1 for 3 cycles while o_id_pc=8 -> o_id_pc=8, o_id_inst constant for 4 cycles, o_imem_addr=12 held; then 12,16 follow with no gap.
- REQ-032: i_redirect=1, target 0x100, at o_id_pc=4 -> next cycle o_id_valid=0, following cycle o_id_pc=0x100 valid.
- REQ-033: i_redirect and i_stall both 1 -> redirect wins; hold_valid cleared; o_id_pc=0x100 valid 2 cycles later once stall drops.
- REQ-034: RESET_PC=32'hFFFF_FFF8 -> o_id_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
- REQ-035: FETCH_MISALIGN_TRAP_EN defined, redirect to 0x102 -> o_fetch_fault=1, o_id_valid=0 until redirect to 0x200 clears it; undefined -> fetch from 0x100, fault 0.
